// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit holding the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, then a sign fix-up cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W = WIDTH;
  localparam logic [5:0] LAST = 6'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  state_t       state;
  logic [5:0]   cnt;
  logic [2*W-1:0] acc;
  logic [W-1:0] opnd;
  logic [W-1:0] quo;
  logic [W:0]   rem;
  logic [W-1:0] a_orig;
  logic         neg_q;
  logic         neg_r;
  logic         is_div;
  logic         b_zero;

  logic         sgn;
  logic [W-1:0] abs_a;
  logic [W-1:0] abs_b;
  logic [W:0]   mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]   shifted;
  logic [W+1:0] diff;
  logic [2*W-1:0] prod;

  always_comb begin
    sgn      = ~op[0];
    abs_a    = (sgn && a[W-1]) ? -a : a;
    abs_b    = (sgn && b[W-1]) ? -b : b;
    mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, opnd};
    mul_next = acc[0] ? {mul_sum, acc[W-1:1]}
                      : {1'b0, acc[2*W-1:1]};
    shifted  = {rem[W-1:0], quo[W-1]};
    diff     = {1'b0, shifted} - {2'b00, opnd};
    prod     = neg_q ? -acc : acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      quo    <= '0;
      rem    <= '0;
      a_orig <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
      b_zero <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                acc    <= {{W{1'b0}}, abs_b};
                opnd   <= op[1] ? abs_b : abs_a;
                quo    <= abs_a;
                rem    <= '0;
                a_orig <= a;
                neg_q  <= sgn & (a[W-1] ^ b[W-1]);
                neg_r  <= sgn & a[W-1];
                is_div <= op[1];
                b_zero <= (b == '0);
                cnt    <= '0;
                busy   <= 1'b1;
                state  <= op[1] ? DIV : MUL;
              end
              3'd4:    hi <= a;
              3'd5:    lo <= a;
              default: ;
            endcase
          end
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt + 6'd1;
          if (cnt == LAST) state <= FIX;
        end
        DIV: begin
          if (!diff[W+1]) begin
            rem <= diff[W:0];
            quo <= {quo[W-2:0], 1'b1};
          end else begin
            rem <= shifted;
            quo <= {quo[W-2:0], 1'b0};
          end
          cnt <= cnt + 6'd1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            hi <= prod[2*W-1:W];
            lo <= prod[W-1:0];
          end else if (b_zero) begin
            // Divide by zero: all-ones quotient, dividend passed through.
            hi <= a_orig;
            lo <= '1;
          end else begin
            hi <= neg_r ? -rem[W-1:0] : rem[W-1:0];
            lo <= neg_q ? -quo : quo;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit.
// Vectors carry hand-computed HI/LO results and latency.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int vecs = 0;
  int errs = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits for done, n counts edges since the accept edge.
  task automatic wait_done(inout int n);
    while (!done && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    tick();
    start = 1'b0;
    n = 0;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    wait_done(n);
    chk({tag, " latency"}, 32'(n), 32'd33);
    chk({tag, " hi"}, hi, ehi);
    chk({tag, " lo"}, lo, elo);
    tick();
    chk({tag, " done width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int gap;
    tick();
    tick();
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();

    run_op("mult -2*3", 3'd0, 32'hFFFF_FFFE, 32'd3,
           32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu -2*3", 3'd1, 32'hFFFF_FFFE, 32'd3,
           32'd2, 32'hFFFF_FFFA);
    run_op("mult 7*-9", 3'd0, 32'd7, 32'hFFFF_FFF7,
           32'hFFFF_FFFF, 32'hFFFF_FFC1);

    // Reset in the middle of a multiply.
    start = 1'b1;
    op = 3'd0;
    a = 32'd7;
    b = 32'd9;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2 reset = 1'b1;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst hi", hi, 32'd0);
    chk("midrst lo", lo, 32'd0);
    #1 reset = 1'b0;
    tick();
    run_op("multu 3*5", 3'd1, 32'd3, 32'd5, 32'd0, 32'd15);

    run_op("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu 7/2", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3);
    run_op("div min/-1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 32'h8000_0000);
    run_op("div 7/-2", 3'd2, 32'd7, 32'hFFFF_FFFE,
           32'd1, 32'hFFFF_FFFD);
    run_op("divu 100/0", 3'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run_op("div -5/0", 3'd2, 32'hFFFF_FFFB, 32'd0,
           32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // MTHI / MTLO on consecutive edges.
    start = 1'b1;
    op = 3'd4;
    a = 32'h1234_5678;
    tick();
    chk("mthi hi", hi, 32'h1234_5678);
    chk("mthi busy", 32'(busy), 32'd0);
    op = 3'd5;
    a = 32'h9ABC_DEF0;
    tick();
    chk("mtlo lo", lo, 32'h9ABC_DEF0);
    chk("mtlo hi", hi, 32'h1234_5678);
    chk("mtlo busy", 32'(busy), 32'd0);
    chk("mtlo done", 32'(done), 32'd0);
    op = 3'd6;
    tick();
    chk("rsvd done", 32'(done), 32'd0);
    chk("rsvd lo", lo, 32'h9ABC_DEF0);

    // MULTU 1*1 with a DIVU start pulse while busy.
    op = 3'd1;
    a = 32'd1;
    b = 32'd1;
    tick();
    start = 1'b0;
    n = 0;
    repeat (4) begin
      tick();
      n++;
    end
    start = 1'b1;
    op = 3'd3;
    a = 32'd9;
    b = 32'd2;
    tick();
    n++;
    start = 1'b0;
    chk("busy-ign busy", 32'(busy), 32'd1);
    chk("busy-ign hi", hi, 32'h1234_5678);
    chk("busy-ign lo", lo, 32'h9ABC_DEF0);
    wait_done(n);
    chk("busy-ign latency", 32'(n), 32'd33);
    chk("busy-ign hi res", hi, 32'd0);
    chk("busy-ign lo res", lo, 32'd1);
    tick();
    chk("busy-ign no queue", 32'(busy), 32'd0);

    // Back-to-back MULTU with start held high.
    start = 1'b1;
    op = 3'd1;
    a = 32'd2;
    b = 32'd2;
    tick();
    n = 0;
    wait_done(n);
    chk("b2b first lat", 32'(n), 32'd33);
    chk("b2b first lo", lo, 32'd4);
    tick();
    gap = 1;
    chk("b2b rearm busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(gap);
    chk("b2b done gap", 32'(gap), 32'd34);
    chk("b2b second lo", lo, 32'd4);
    chk("b2b second hi", hi, 32'd0);
    tick();
    chk("b2b idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
